// File: rtl/sap_core.sv
// sap_core: small accumulator CPU with a FETCH / EXEC / HALT control loop.
// Optional zero flag and JZ instruction are enabled by defining SAP_CORE_ZERO_FLAG_EN.
module sap_core #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = WIDTH - 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ack,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  halted,
   output logic                  err
);

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpOut = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpLdi = 4'h7;
   localparam logic [3:0] OpJc  = 4'h8;
   localparam logic [3:0] OpJnc = 4'h9;
`ifdef SAP_CORE_ZERO_FLAG_EN
   localparam logic [3:0] OpJz  = 4'hA;
`endif
   localparam logic [3:0] OpHlt = 4'hF;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [WIDTH-1:0]      ir_q, ir_d;
   logic                  carry_q, carry_d;
   logic                  err_q, err_d;
`ifdef SAP_CORE_ZERO_FLAG_EN
   logic                  z_q, z_d;
`endif

   logic [3:0]            opcode;
   logic [ADDR_WIDTH-1:0] operand;
   logic                  is_read;
   logic                  illegal;
   logic [WIDTH-1:0]      m_val;
   logic [WIDTH:0]        sum;

   assign opcode  = ir_q[WIDTH-1 -: 4];
   assign operand = ir_q[ADDR_WIDTH-1:0];
   // B holds the last memory operand; on the ack cycle the ALU takes the fresh data directly.
   assign m_val   = (state_q == StExec && mem_ack) ? mem_rdata : b_q;
   assign sum     = {1'b0, a_q} + {1'b0, m_val};

   // Instruction class decode.
   always_comb begin
      is_read = 1'b0;
      illegal = 1'b0;
      unique case (opcode)
         OpLda, OpAdd, OpSub: is_read = 1'b1;
         OpNop, OpSta, OpOut, OpJmp, OpLdi, OpJc, OpJnc, OpHlt: ;
`ifdef SAP_CORE_ZERO_FLAG_EN
         OpJz: ;
`endif
         default: illegal = 1'b1;
      endcase
   end

   // State register; synchronous reset returns to FETCH from anywhere, HALT included.
   always_ff @(posedge clk) begin
      if (!rstn) state_q <= StFetch;
      else       state_q <= state_d;
   end

   // Next-state logic; requests hold their state until ack/ready.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (mem_ack) state_d = StExec;
         StExec: begin
            if (illegal || opcode == OpHlt) begin
               state_d = StHalt;
            end else if (is_read || opcode == OpSta) begin
               if (mem_ack) state_d = StFetch;
            end else if (opcode == OpOut) begin
               if (out_ready) state_d = StFetch;
            end else begin
               state_d = StFetch;
            end
         end
         default: state_d = StHalt;
      endcase
   end

   // Outputs; requests are masked while rstn is low so an aborted request cannot complete.
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      out_valid = 1'b0;
      mem_addr  = operand;
      unique case (state_q)
         StFetch: begin
            mem_rd   = rstn;
            mem_addr = pc_q;
         end
         StExec: begin
            mem_rd    = rstn & is_read;
            mem_wr    = rstn & (opcode == OpSta);
            out_valid = rstn & (opcode == OpOut);
         end
         default: ;
      endcase
   end

   assign mem_wdata = a_q;
   assign out_data  = a_q;
   assign halted    = (state_q == StHalt);
   assign err       = err_q;

   // Datapath next-state: register updates happen only on the completing cycle.
   always_comb begin
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      ir_d    = ir_q;
      carry_d = carry_q;
      err_d   = err_q;
      unique case (state_q)
         StFetch: begin
            if (mem_ack) begin
               ir_d = mem_rdata;
               pc_d = pc_q + ADDR_WIDTH'(1);
            end
         end
         StExec: begin
            unique case (opcode)
               OpLda: if (mem_ack) begin
                  b_d = mem_rdata;
                  a_d = m_val;
               end
               OpAdd: if (mem_ack) begin
                  b_d     = mem_rdata;
                  a_d     = sum[WIDTH-1:0];
                  carry_d = sum[WIDTH];
               end
               OpSub: if (mem_ack) begin
                  b_d     = mem_rdata;
                  a_d     = a_q - m_val;
                  carry_d = (a_q >= m_val);
               end
               OpLdi: a_d = WIDTH'(operand);
               OpJmp: pc_d = operand;
               OpJc:  if (carry_q)  pc_d = operand;
               OpJnc: if (!carry_q) pc_d = operand;
`ifdef SAP_CORE_ZERO_FLAG_EN
               OpJz:  if (z_q) pc_d = operand;
`endif
               OpNop, OpSta, OpOut, OpHlt: ;
               default: err_d = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

`ifdef SAP_CORE_ZERO_FLAG_EN
   // Zero flag follows every instruction that writes A.
   always_comb begin
      z_d = z_q;
      if (state_q == StExec && ((is_read && mem_ack) || opcode == OpLdi)) z_d = (a_d == '0);
   end

   // Zero flag register.
   always_ff @(posedge clk) begin
      if (!rstn) z_q <= 1'b0;
      else       z_q <= z_d;
   end
`endif

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ir_q    <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

endmodule
